// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32 core.
// Keeps at most one fetch outstanding to instruction memory. A one-entry
// buffer holds a returned word while decode is stalled. A branch redirect
// flushes IF/ID and kills an in-flight wrong-path fetch.
module if_stage #(
    parameter int unsigned    XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]    NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic            buf_valid_q, buf_valid_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     buf_instr_q, buf_instr_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_instr_q, id_instr_d;

    logic accept;
    logic slot_free;

    // Requests are only issued from S_REQ; the address is the live PC,
    // which stays put until the request is accepted or a branch redirects it.
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;
    assign slot_free = !id_valid_q || !stall;

    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;
    assign id_opcode = id_instr_q[6:0];

    // Next-state, PC, buffer and IF/ID update; branch redirect overrides all.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        kill_d      = kill_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;

        // Decode consumed the current slot; a fill below may refill it.
        if (id_valid_q && !stall) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end

        case (state_q)
            S_REQ: begin
                if (accept) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (slot_free) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = req_pc_q;
                        id_instr_d = imem_rdata;
                        state_d    = S_REQ;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = req_pc_q;
                        buf_instr_d = imem_rdata;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    id_valid_d  = 1'b1;
                    id_pc_d     = buf_pc_q;
                    id_instr_d  = buf_instr_q;
                    buf_valid_d = 1'b0;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (branch_taken) begin
            pc_d        = {branch_target[XLEN-1:2], 2'b00};
            id_valid_d  = 1'b0;
            id_instr_d  = NOP_INSTR;
            buf_valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    // An accepted fetch this cycle is wrong-path: kill its data.
                    if (accept) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State and datapath registers, all asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            kill_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_instr_q  <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: the bench plays the instruction memory
// cycle by cycle and checks expected values worked out by hand.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    int checks = 0;
    int errors = 0;

    if_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        #2; step(); step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %0b exp 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h exp 00000000", id_pc); end
        checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL rst_id_instr: got %h exp 00000013", id_instr); end
        checks++; if (id_opcode !== 7'h13) begin errors++; $display("FAIL rst_id_opcode: got %h exp 13", id_opcode); end
        reset = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req: got %0b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 00000000", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        imem_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req: got %0b exp 0", imem_req); end
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL basic_v0: got %0b exp 1", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL basic_pc0: got %h exp 00000000", id_pc); end
        checks++; if (id_opcode !== 7'h33) begin errors++; $display("FAIL basic_op0: got %h exp 33", id_opcode); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL basic_addr1: got %h exp 00000004", imem_addr); end
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %0b exp 0", id_valid); end
        checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL basic_nop: got %h exp 00000013", id_instr); end
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0003;
        step();
        checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL basic_pc1: got %h exp 00000004", id_pc); end
        checks++; if (id_opcode !== 7'h03) begin errors++; $display("FAIL basic_op1: got %h exp 03", id_opcode); end
        imem_rvalid = 1'b0;
    endtask

    task automatic test_stall_hold();
        stall = 1'b1; imem_ready = 1'b1;
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr8: got %h exp 00000008", imem_addr); end
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
        step();
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %0b exp 0", i, imem_req); end
            checks++; if (id_pc !== 32'h4 || id_instr !== 32'h3 || id_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold[%0d]: got v=%0b pc=%h ins=%h exp v=1 pc=00000004 ins=00000003", i, id_valid, id_pc, id_instr); end
            step();
        end
        stall = 1'b0;
        step();
        checks++; if (id_pc !== 32'h8 || id_instr !== 32'h00A0_0093 || id_valid !== 1'b1)
            begin errors++; $display("FAIL stall_release: got v=%0b pc=%h ins=%h exp v=1 pc=00000008 ins=00a00093", id_valid, id_pc, id_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC)
            begin errors++; $display("FAIL stall_next_req: got req=%0b addr=%h exp req=1 addr=0000000c", imem_req, imem_addr); end
        step();
        imem_ready = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stall_consumed: got %0b exp 0", id_valid); end
    endtask

    task automatic test_branch_wait();
        branch_taken = 1'b1; branch_target = 32'h103;
        step();
        branch_taken = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h13)
            begin errors++; $display("FAIL bw_drop: got v=%0b ins=%h exp v=0 ins=00000013", id_valid, id_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
            begin errors++; $display("FAIL bw_addr: got req=%0b addr=%h exp req=1 addr=00000100", imem_req, imem_addr); end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bw_still_empty: got %0b exp 0", id_valid); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
        step();
        imem_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100)
            begin errors++; $display("FAIL bw_fill: got v=%0b pc=%h exp v=1 pc=00000100", id_valid, id_pc); end
    endtask

    task automatic test_ready_low();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104)
                begin errors++; $display("FAIL rl_hold[%0d]: got req=%0b addr=%h exp req=1 addr=00000104", i, imem_req, imem_addr); end
            step();
        end
        branch_taken = 1'b1; branch_target = 32'h0E;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC)
            begin errors++; $display("FAIL rl_redirect: got req=%0b addr=%h exp req=1 addr=0000000c", imem_req, imem_addr); end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00C0_0193;
        step();
        imem_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hC)
            begin errors++; $display("FAIL rl_no_kill: got v=%0b pc=%h exp v=1 pc=0000000c", id_valid, id_pc); end
    endtask

    task automatic test_branch_accept();
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL ba_addr: got %h exp 00000010", imem_addr); end
        imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        branch_taken = 1'b0; imem_ready = 1'b0;
        checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0)
            begin errors++; $display("FAIL ba_wait: got req=%0b v=%0b exp req=0 v=0", imem_req, id_valid); end
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1033;
        step();
        imem_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ba_drop: got %0b exp 0", id_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200)
            begin errors++; $display("FAIL ba_target: got req=%0b addr=%h exp req=1 addr=00000200", imem_req, imem_addr); end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0063;
        step();
        imem_rvalid = 1'b0;
        checks++; if (id_pc !== 32'h200 || id_opcode !== 7'h63)
            begin errors++; $display("FAIL ba_fill: got pc=%h op=%h exp pc=00000200 op=63", id_pc, id_opcode); end
        checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL ba_next: got %h exp 00000204", imem_addr); end
    endtask

    task automatic test_reset_mid();
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_wait: got %0b exp 0", imem_req); end
        #2; reset = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h13)
            begin errors++; $display("FAIL rm_async: got req=%0b addr=%h v=%0b pc=%h ins=%h exp 1 00000000 0 00000000 00000013", imem_req, imem_addr, id_valid, id_pc, id_instr); end
        step();
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        step();
        imem_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h13 || id_opcode !== 7'h13)
            begin errors++; $display("FAIL rm_late_rvalid: got v=%0b ins=%h op=%h exp v=0 ins=00000013 op=13", id_valid, id_instr, id_opcode); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin errors++; $display("FAIL rm_first_req: got req=%0b addr=%h exp req=1 addr=00000000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_branch_wait();
        test_ready_low();
        test_branch_accept();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
